// File: rtl/fcvt_s_w_seq.sv
// fcvt_s_w_seq: multi-cycle int32/uint32 to binary32 converter, round-to-nearest-even.
// Normalisation shifts up to SHIFT_STEP bits per cycle.
module fcvt_s_w_seq #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_int,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_inexact
);
   localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3;
   generate
      if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 && SHIFT_STEP != 8 && SHIFT_STEP != 16) begin : g_bad_step
         $error("fcvt_s_w_seq: SHIFT_STEP must be 1, 2, 4, 8 or 16");
      end
   endgenerate
   logic [1:0]  state;
   logic        sign;
   logic [31:0] mag, mag_in;
   logic [7:0]  exp;
   logic        g, s, up;
   logic [23:0] m_sum;
   assign in_ready  = state == IDLE && !rst;
   assign out_valid = state == DONE;
   assign mag_in    = (in_signed & in_int[31]) ? -in_int : in_int;
   // bit 23 of m_sum is the mantissa carry-out; the low 23 bits are then already zero
   always_comb begin
      g     = mag[7];
      s     = |mag[6:0];
      up    = g & (s | mag[8]);
      m_sum = {1'b0, mag[30:8]} + 24'(up);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sign        <= 1'b0;
         mag         <= '0;
         exp         <= '0;
         out_res     <= '0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sign <= in_signed & in_int[31];
               mag  <= mag_in;
               exp  <= 8'd158;
               if (mag_in == '0) begin
                  out_res     <= '0;
                  out_inexact <= 1'b0;
                  state       <= DONE;
               end else begin
                  state <= NORM;
               end
            end
            NORM: if (mag[31]) begin
               state <= ROUND;
            end else if (SHIFT_STEP > 1 && mag[31 -: SHIFT_STEP] == '0) begin
               mag <= mag << SHIFT_STEP;
               exp <= exp - 8'(SHIFT_STEP);
            end else begin
               mag <= mag << 1;
               exp <= exp - 8'd1;
            end
            ROUND: begin
               out_res     <= {sign, exp + 8'(m_sum[23]), m_sum[22:0]};
               out_inexact <= g | s;
               state       <= DONE;
            end
            default: if (out_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fcvt_s_w_seq.sv
// tb_fcvt_s_w_seq: table-driven checks of the converter plus backpressure, reset and SHIFT_STEP=4 sequences.
module tb_fcvt_s_w_seq;
   logic clk = 0, rst = 1;
   logic in_valid = 0, in_signed = 0, out_ready = 0;
   logic [31:0] in_int = 0;
   logic in_ready, out_valid, out_inexact;
   logic [31:0] out_res;
   logic v4 = 0, s4 = 0, or4 = 0;
   logic [31:0] i4 = 0;
   logic ir4, ov4, inx4;
   logic [31:0] res4;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   fcvt_s_w_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_int(in_int),
      .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_inexact(out_inexact));
   fcvt_s_w_seq #(.SHIFT_STEP(4)) u4 (.clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_int(i4),
      .in_signed(s4), .out_valid(ov4), .out_ready(or4), .out_res(res4), .out_inexact(inx4));
   typedef struct {
      logic [31:0] val;
      logic        sgn;
      logic [31:0] res;
      logic        inx;
      int          lat;
   } vec_t;
   vec_t vecs[13];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask
   // drive one operand into dut, wait for the result, check it, leave it pending in DONE
   task automatic issue(input logic [31:0] v, input logic sg, output int lat);
      int n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      check("in_ready_before_issue", 32'(in_ready), 1);
      in_int = v; in_signed = sg; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
   endtask
   task automatic handshake();
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("in_ready_after_handshake", 32'(in_ready), 1);
   endtask
   task automatic run4(input logic [31:0] v, input logic sg, input logic [31:0] er, input int el);
      int lat = 0;
      i4 = v; s4 = sg; v4 = 1;
      @(posedge clk); #1;
      v4 = 0;
      while (!ov4 && lat < 100) begin @(posedge clk); #1; lat++; end
      check("step4_res", res4, er);
      check("step4_latency", 32'(lat), 32'(el));
      or4 = 1;
      @(posedge clk); #1;
      or4 = 0;
   endtask
   initial begin
      int lat;
      logic [31:0] held_res;
      logic held_inx;
      vecs[0]  = '{32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 33};
      vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 33};
      vecs[2]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 2};
      vecs[3]  = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 2};
      vecs[4]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0};
      vecs[5]  = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 9};
      vecs[6]  = '{32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 9};
      vecs[7]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 2};
      vecs[8]  = '{32'h0000_0003, 1'b1, 32'h4040_0000, 1'b0, 32};
      vecs[9]  = '{32'd1000,      1'b1, 32'h447A_0000, 1'b0, 24};
      vecs[10] = '{-32'sd1000,    1'b1, 32'hC47A_0000, 1'b0, 24};
      vecs[11] = '{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1, 3};
      vecs[12] = '{32'h1234_5678, 1'b0, 32'h4D91_A2B4, 1'b1, 5};
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 0);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_res", out_res, 0);
      check("reset_out_inexact", 32'(out_inexact), 0);
      rst = 0;
      #1;
      check("idle_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].val, vecs[i].sgn, lat);
         check($sformatf("vec%0d_res", i), out_res, vecs[i].res);
         check($sformatf("vec%0d_inexact", i), 32'(out_inexact), 32'(vecs[i].inx));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         handshake();
      end
      // backpressure, then back-to-back accept right after the handshake
      issue(32'h0100_0003, 1'b0, lat);
      held_res = out_res; held_inx = out_inexact;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_out_res", out_res, held_res);
         check("bp_out_inexact", 32'(out_inexact), 32'(held_inx));
         check("bp_in_ready", 32'(in_ready), 0);
      end
      check("bp_value", held_res, 32'h4B80_0002);
      handshake();
      issue(32'hFFFF_FFFF, 1'b1, lat);
      check("b2b_res", out_res, 32'hBF80_0000);
      check("b2b_latency", 32'(lat), 33);
      handshake();
      // reset in the middle of normalisation
      in_int = 32'h0000_0001; in_signed = 1; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_in_ready_rst_high", 32'(in_ready), 0);
      check("midrst_out_res", out_res, 0);
      rst = 0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 1);
      lat = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      check("midrst_no_stale_result", 32'(lat), 0);
      run4(32'h0000_0001, 1'b1, 32'h3F80_0000, 12);
      run4(32'd1000, 1'b1, 32'h447A_0000, 9);
      run4(32'h0100_0001, 1'b0, 32'h4B80_0000, 6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
